// File: rtl/iterative_divider_core_if.sv
// Start/done handshake and operand/result bus of the
// iterative divider.
interface iterative_divider_core_if #(
    parameter int WORD_LENGTH = 16
);
    logic                   start;
    logic [WORD_LENGTH-1:0] dividend;
    logic [WORD_LENGTH-1:0] divisor;
    logic [WORD_LENGTH-1:0] quotient;
    logic [WORD_LENGTH-1:0] remainder;
    logic                   ready;
    logic                   done;
    logic                   div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  quotient,
        input  remainder,
        input  ready,
        input  done,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output quotient,
        output remainder,
        output ready,
        output done,
        output div_by_zero
    );
endinterface

// File: rtl/iterative_divider_core.sv
// Unsigned radix-2 restoring divider, one quotient bit
// per clock, with a start/done control FSM.
module iterative_divider_core #(
    parameter int WORD_LENGTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    iterative_divider_core_if.slave   bus
);
    function automatic int calc_bits(input int n);
        int b;
        b = 1;
        for (int i = 1; i < 32; i++)
            if ((1 << b) < n)
                b = b + 1;
        return b;
    endfunction

    localparam int NBITS_FOR_COUNTER = calc_bits(WORD_LENGTH);
    localparam int WL = WORD_LENGTH;
    localparam logic [NBITS_FOR_COUNTER-1:0] LAST_STEP =
        NBITS_FOR_COUNTER'(WL - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [NBITS_FOR_COUNTER-1:0] counter;
    logic                         first;
    logic                         last;
    logic                         zero_step;

    // dq starts as the dividend; quotient bits shift in at
    // the bottom as dividend bits leave the top.
    logic [WL-1:0] dq;
    logic [WL-1:0] divisor_reg;
    logic [WL-1:0] r;
    logic [WL-1:0] quotient;
    logic [WL-1:0] remainder;
    logic          div_by_zero;

    logic [WL:0]   r_shift;
    logic          ge;
    logic [WL-1:0] r_next;
    logic [WL-1:0] q_next;

    assign first     = (counter == '0);
    assign last      = (counter == LAST_STEP);
    assign zero_step = first && (divisor_reg == '0);

    always_comb begin
        r_shift = {r, dq[WL-1]};
        ge      = (r_shift >= {1'b0, divisor_reg});
        r_next  = ge ? (r_shift[WL-1:0] - divisor_reg)
                     : r_shift[WL-1:0];
        q_next  = {dq[WL-2:0], ge};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = DIVIDE;
            DIVIDE:  if (zero_step || last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter     <= '0;
            dq          <= '0;
            divisor_reg <= '0;
            r           <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        dq          <= bus.dividend;
                        divisor_reg <= bus.divisor;
                        r           <= '0;
                        counter     <= '0;
                        div_by_zero <= 1'b0;
                    end
                end
                DIVIDE: begin
                    if (zero_step) begin
                        quotient    <= '1;
                        remainder   <= dq;
                        div_by_zero <= 1'b1;
                        counter     <= '0;
                    end else begin
                        dq      <= q_next;
                        r       <= r_next;
                        counter <= last ? '0 : counter + 1'b1;
                        if (last) begin
                            quotient  <= q_next;
                            remainder <= r_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient    = quotient;
    assign bus.remainder   = remainder;
    assign bus.div_by_zero = div_by_zero;
    assign bus.ready       = (state == IDLE);
    assign bus.done        = (state == DONE);
endmodule

// File: tb/tb_iterative_divider_core.sv
// Directed-vector bench for iterative_divider_core.
// Expected values are hand-computed constants.
module tb_iterative_divider_core;
    localparam int WL = 16;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    iterative_divider_core_if #(.WORD_LENGTH(WL)) bus ();

    iterative_divider_core #(.WORD_LENGTH(WL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [15:0] a,
                          input logic [15:0] b);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic op(input string tag,
                      input logic [15:0] a,
                      input logic [15:0] b,
                      input logic [15:0] eq,
                      input logic [15:0] er,
                      input logic edbz,
                      input int elat);
        int lat;
        launch(a, b);
        check({tag, "_busy"}, 32'(bus.ready), 32'd0);
        wait_done(lat);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_q"}, 32'(bus.quotient), 32'(eq));
        check({tag, "_r"}, 32'(bus.remainder), 32'(er));
        check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(edbz));
        tick();
        check({tag, "_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_rdy"}, 32'(bus.ready), 32'd1);
    endtask

    initial begin
        int lat;
        int pulses;
        int prev;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) tick();
        check("rst_q", 32'(bus.quotient), 32'd0);
        check("rst_r", 32'(bus.remainder), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        check("rst_rdy", 32'(bus.ready), 32'd1);
        reset = 1'b1;
        tick();

        op("nom", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16);
        op("max1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 16);
        op("maxmax", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0,
           1'b0, 16);
        op("small", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 16);
        op("dz", 16'h1234, 16'd0, 16'hFFFF, 16'h1234,
           1'b1, 1);
        op("afterdz", 16'd10, 16'd3, 16'd3, 16'd1, 1'b0, 16);

        // second start lands mid-operation and must be dropped
        launch(16'd200, 16'd9);
        repeat (4) tick();
        bus.dividend = 16'd50;
        bus.divisor  = 16'd5;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.dividend = 16'hAAAA;
        bus.divisor  = 16'd3;
        check("busy_hold_q", 32'(bus.quotient), 32'd3);
        check("busy_hold_r", 32'(bus.remainder), 32'd1);
        wait_done(lat);
        check("busy_lat", lat, 11);
        check("busy_q", 32'(bus.quotient), 32'd22);
        check("busy_r", 32'(bus.remainder), 32'd2);
        tick();
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) pulses++;
            tick();
        end
        check("busy_extra_done", pulses, 0);

        // asynchronous reset mid-operation
        launch(16'd1000, 16'd7);
        repeat (8) tick();
        #2;
        reset = 1'b0;
        #1;
        check("mrst_q", 32'(bus.quotient), 32'd0);
        check("mrst_r", 32'(bus.remainder), 32'd0);
        check("mrst_rdy", 32'(bus.ready), 32'd1);
        check("mrst_done", 32'(bus.done), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) pulses++;
            tick();
        end
        check("mrst_no_done", pulses, 0);
        op("post_rst", 16'd81, 16'd9, 16'd9, 16'd0, 1'b0, 16);

        // start held high: one result every 18 cycles
        bus.dividend = 16'd1000;
        bus.divisor  = 16'd10;
        bus.start    = 1'b1;
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            wait_done(lat);
            check("b2b_seen", 32'(bus.done), 32'd1);
            check("b2b_q", 32'(bus.quotient), 32'd100);
            check("b2b_r", 32'(bus.remainder), 32'd0);
            if (k > 0) check("b2b_period", cyc - prev, 18);
            prev = cyc;
            tick();
            check("b2b_width", 32'(bus.done), 32'd0);
        end
        bus.start = 1'b0;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end
endmodule
